// File: rtl/axi_xbar_pkg.sv
// Shared types and default sizing for the AXI R-channel crossbar.
//   r_beat_t   : master-side R beat {id, data, resp, last}
//   state_e    : arbitration FSM states {IDLE, LOCK}
//   DEF_*      : default crossbar sizing used by the top-level parameters
//   MI_BITS    : width of the master-index prefix on slave-side IDs
//   S_IDX_BITS : width of a slave index
package axi_xbar_pkg;

    localparam int unsigned DEF_NUM_S     = 7;
    localparam int unsigned DEF_NUM_M     = 3;
    localparam int unsigned DEF_ID_BITS   = 4;
    localparam int unsigned DEF_IDS_BITS  = 8;
    localparam int unsigned DEF_DATA_BITS = 32;
    localparam int unsigned DEF_RESP_BITS = 2;

    localparam int unsigned MI_BITS    = DEF_IDS_BITS - DEF_ID_BITS;
    localparam int unsigned S_IDX_BITS = $clog2(DEF_NUM_S);

    typedef struct packed {
        logic [DEF_ID_BITS-1:0]   id;
        logic [DEF_DATA_BITS-1:0] data;
        logic [DEF_RESP_BITS-1:0] resp;
        logic                     last;
    } r_beat_t;

    typedef enum logic {IDLE, LOCK} state_e;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: rotate requests so ptr becomes bit 0, pick the lowest
// set bit, rotate the one-hot grant back.
//   req : request vector
//   ptr : index with highest priority (must be < N)
//   gnt : one-hot grant, all zero when no request
module rr_arb #(
    parameter int unsigned N        = 7,
    parameter int unsigned PTR_BITS = $clog2(N)
) (
    input  logic [N-1:0]        req,
    input  logic [PTR_BITS-1:0] ptr,
    output logic [N-1:0]        gnt
);

    logic [2*N-1:0] req_rot2;
    logic [2*N-1:0] gnt_rot2;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;
    logic           found;

    always_comb begin
        req_rot2 = {req, req} >> ptr;
        rot_req  = req_rot2[N-1:0];
        rot_gnt  = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot_req[i] && !found) begin
                rot_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
        gnt_rot2 = {rot_gnt, rot_gnt} << ptr;
        gnt      = gnt_rot2[2*N-1:N];
    end

endmodule

// File: rtl/axi_r_xbar_rr.sv
// AXI read-data channel crossbar: NUM_S slaves, round-robin arbitration with the
// grant held for a whole burst, routing by the master-index prefix of the slave ID.
// Beats whose prefix is >= NUM_M are sunk and flagged on dec_err_o.
//   clk, rst (async, active-low)
//   s_id_i/s_data_i/s_resp_i/s_last_i/s_valid_i/s_ready_o : packed slave ports
//   m_id_o/m_data_o/m_resp_o/m_last_o/m_valid_o/m_ready_i : packed master ports
//   dec_err_o : high for each sunk (undecodable) beat
// Build option AXI_R_XBAR_REGSLICE_EN: 2-entry skid buffer per master port,
// 1-cycle latency, no combinational m_ready_i -> s_ready_o path.
module axi_r_xbar_rr
    import axi_xbar_pkg::*;
#(
    parameter int unsigned NUM_S     = DEF_NUM_S,
    parameter int unsigned NUM_M     = DEF_NUM_M,
    parameter int unsigned ID_BITS   = DEF_ID_BITS,
    parameter int unsigned IDS_BITS  = DEF_IDS_BITS,
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned RESP_BITS = DEF_RESP_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_S*IDS_BITS-1:0]  s_id_i,
    input  logic [NUM_S*DATA_BITS-1:0] s_data_i,
    input  logic [NUM_S*RESP_BITS-1:0] s_resp_i,
    input  logic [NUM_S-1:0]           s_last_i,
    input  logic [NUM_S-1:0]           s_valid_i,
    output logic [NUM_S-1:0]           s_ready_o,
    output logic [NUM_M*ID_BITS-1:0]   m_id_o,
    output logic [NUM_M*DATA_BITS-1:0] m_data_o,
    output logic [NUM_M*RESP_BITS-1:0] m_resp_o,
    output logic [NUM_M-1:0]           m_last_o,
    output logic [NUM_M-1:0]           m_valid_o,
    input  logic [NUM_M-1:0]           m_ready_i,
    output logic                       dec_err_o
);

    localparam int unsigned MIDX_W = IDS_BITS - ID_BITS;
    localparam int unsigned SIDX_W = $clog2(NUM_S);

    state_e               state_q;
    logic [SIDX_W-1:0]    rr_ptr_q;
    logic [SIDX_W-1:0]    lock_q;
    logic [NUM_S-1:0]     arb_gnt;
    logic [SIDX_W-1:0]    sel;
    logic [SIDX_W-1:0]    next_ptr;
    logic                 granted;
    logic                 sel_valid_raw;
    logic                 sel_valid;
    logic                 sel_ready;
    logic                 sel_last;
    logic [IDS_BITS-1:0]  sel_id;
    logic [DATA_BITS-1:0] sel_data;
    logic [RESP_BITS-1:0] sel_resp;
    logic [MIDX_W-1:0]    mi;
    logic                 route_ok;
    logic                 hs;

    rr_arb #(
        .N        (NUM_S),
        .PTR_BITS (SIDX_W)
    ) u_rr_arb (
        .req (s_valid_i),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // While locked, the arbiter is ignored and the burst owner stays selected.
    always_comb begin
        sel = lock_q;
        if (state_q == IDLE) begin
            sel = '0;
            for (int k = 0; k < NUM_S; k++) begin
                if (arb_gnt[k]) sel = SIDX_W'(k);
            end
        end
    end

    always_comb begin
        sel_valid_raw = 1'b0;
        sel_id        = '0;
        sel_data      = '0;
        sel_resp      = '0;
        sel_last      = 1'b0;
        for (int k = 0; k < NUM_S; k++) begin
            if (int'(sel) == k) begin
                sel_valid_raw = s_valid_i[k];
                sel_id        = s_id_i[k*IDS_BITS +: IDS_BITS];
                sel_data      = s_data_i[k*DATA_BITS +: DATA_BITS];
                sel_resp      = s_resp_i[k*RESP_BITS +: RESP_BITS];
                sel_last      = s_last_i[k];
            end
        end
    end

    // Reset gates everything so ready/valid drop as soon as rst falls.
    assign granted   = rst & ((state_q == LOCK) | (|s_valid_i));
    assign sel_valid = granted & sel_valid_raw;
    assign mi        = sel_id[IDS_BITS-1:ID_BITS];
    assign route_ok  = 32'(mi) < NUM_M;
    assign hs        = sel_valid & sel_ready;
    assign dec_err_o = hs & ~route_ok;
    assign next_ptr  = (int'(sel) == int'(NUM_S) - 1) ? '0 : sel + 1'b1;

    always_comb begin
        s_ready_o = '0;
        for (int k = 0; k < NUM_S; k++) begin
            s_ready_o[k] = granted & (int'(sel) == k) & sel_ready;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            lock_q   <= '0;
        end else if (hs) begin
            if (sel_last) begin
                state_q  <= IDLE;
                rr_ptr_q <= next_ptr;
            end else begin
                state_q <= LOCK;
                lock_q  <= sel;
            end
        end
    end

`ifdef AXI_R_XBAR_REGSLICE_EN
    r_beat_t          beat_in;
    r_beat_t          mem_q [NUM_M][2];
    logic [1:0]       cnt_q [NUM_M];
    logic [NUM_M-1:0] wr_q;
    logic [NUM_M-1:0] rd_q;
    logic [NUM_M-1:0] push;
    logic [NUM_M-1:0] pop;

    // Ready comes only from buffer occupancy, never from m_ready_i.
    always_comb begin
        sel_ready = 1'b1;
        for (int m = 0; m < NUM_M; m++) begin
            if (route_ok && int'(mi) == m) sel_ready = (cnt_q[m] != 2'd2);
        end
    end

    always_comb begin
        beat_in   = '{id: sel_id[ID_BITS-1:0], data: sel_data, resp: sel_resp, last: sel_last};
        m_valid_o = '0;
        m_id_o    = '0;
        m_data_o  = '0;
        m_resp_o  = '0;
        m_last_o  = '0;
        for (int m = 0; m < NUM_M; m++) begin
            push[m]      = hs & route_ok & (int'(mi) == m);
            m_valid_o[m] = (cnt_q[m] != 2'd0);
            pop[m]       = m_valid_o[m] & m_ready_i[m];
            m_id_o[m*ID_BITS +: ID_BITS]       = mem_q[m][rd_q[m]].id;
            m_data_o[m*DATA_BITS +: DATA_BITS] = mem_q[m][rd_q[m]].data;
            m_resp_o[m*RESP_BITS +: RESP_BITS] = mem_q[m][rd_q[m]].resp;
            m_last_o[m]                        = mem_q[m][rd_q[m]].last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int m = 0; m < NUM_M; m++) cnt_q[m] <= 2'd0;
        end else begin
            wr_q <= wr_q ^ push;
            rd_q <= rd_q ^ pop;
            for (int m = 0; m < NUM_M; m++) begin
                cnt_q[m] <= cnt_q[m] + {1'b0, push[m]} - {1'b0, pop[m]};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int m = 0; m < NUM_M; m++) begin
            if (push[m]) mem_q[m][wr_q[m]] <= beat_in;
        end
    end
`else
    always_comb begin
        sel_ready = 1'b1;
        for (int m = 0; m < NUM_M; m++) begin
            if (route_ok && int'(mi) == m) sel_ready = m_ready_i[m];
        end
    end

    // Payload is broadcast; only the routed master sees valid.
    always_comb begin
        m_id_o    = {NUM_M{sel_id[ID_BITS-1:0]}};
        m_data_o  = {NUM_M{sel_data}};
        m_resp_o  = {NUM_M{sel_resp}};
        m_last_o  = {NUM_M{sel_last}};
        m_valid_o = '0;
        for (int m = 0; m < NUM_M; m++) begin
            m_valid_o[m] = sel_valid & route_ok & (int'(mi) == m);
        end
    end
`endif

endmodule

// File: tb/tb_axi_r_xbar_rr.sv
// Self-checking bench for axi_r_xbar_rr (combinational build): directed bursts
// followed by randomized AXI-legal bursts, checked every cycle against a
// behavioural model holding a lock owner and a round-robin pointer.
module tb_axi_r_xbar_rr;

    localparam int NUM_S = 7, NUM_M = 3, ID_BITS = 4, IDS_BITS = 8;
    localparam int DATA_BITS = 32, RESP_BITS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NUM_S*IDS_BITS-1:0]  s_id = '0;
    logic [NUM_S*DATA_BITS-1:0] s_data = '0;
    logic [NUM_S*RESP_BITS-1:0] s_resp = '0;
    logic [NUM_S-1:0]           s_last = '0;
    logic [NUM_S-1:0]           s_valid = '0;
    logic [NUM_S-1:0]           s_ready;
    logic [NUM_M*ID_BITS-1:0]   m_id;
    logic [NUM_M*DATA_BITS-1:0] m_data;
    logic [NUM_M*RESP_BITS-1:0] m_resp;
    logic [NUM_M-1:0]           m_last;
    logic [NUM_M-1:0]           m_valid;
    logic [NUM_M-1:0]           m_ready = '0;
    logic                       dec_err;

    always #5 clk = ~clk;

    axi_r_xbar_rr dut (
        .clk       (clk),
        .rst       (rst),
        .s_id_i    (s_id),
        .s_data_i  (s_data),
        .s_resp_i  (s_resp),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_id_o    (m_id),
        .m_data_o  (m_data),
        .m_resp_o  (m_resp),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .dec_err_o (dec_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int rem [NUM_S];
    logic [7:0] bid [NUM_S];
    bit rand_mode = 0;
    logic [NUM_S-1:0] rdy_smp;

    // Model state: burst owner (-1 = none) and the slave with top priority.
    int mdl_ptr  = 0;
    int mdl_lock = -1;
    bit hs_now;
    bit hs_last;
    int hs_slave;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic new_beat(input int k);
        s_data[k*DATA_BITS +: DATA_BITS] = $urandom;
        s_resp[k*RESP_BITS +: RESP_BITS] = 2'($urandom_range(0, 3));
    endtask

    task automatic apply();
        for (int k = 0; k < NUM_S; k++) begin
            s_valid[k] = rem[k] > 0;
            s_last[k]  = rem[k] == 1;
            s_id[k*IDS_BITS +: IDS_BITS] = bid[k];
        end
    endtask

    task automatic start_burst(input int k, input int len, input logic [7:0] id);
        rem[k] = len;
        bid[k] = id;
        new_beat(k);
        apply();
    endtask

    task automatic evaluate();
        logic [NUM_S-1:0] e_rdy;
        logic [NUM_M-1:0] e_mv;
        logic e_dec;
        int g;
        int mi;
        e_rdy = '0; e_mv = '0; e_dec = 1'b0; g = -1; hs_now = 0;
        if (rst) begin
            if (mdl_lock >= 0) g = mdl_lock;
            else begin
                for (int i = 0; i < NUM_S; i++) begin
                    int k;
                    k = (mdl_ptr + i) % NUM_S;
                    if (g < 0 && s_valid[k]) g = k;
                end
            end
        end
        if (g >= 0) begin
            mi = int'(s_id[g*IDS_BITS + ID_BITS +: IDS_BITS - ID_BITS]);
            if (mi < NUM_M) begin
                e_mv[mi] = s_valid[g];
                e_rdy[g] = m_ready[mi];
            end else begin
                e_rdy[g] = 1'b1;
                e_dec    = s_valid[g];
            end
            hs_now   = s_valid[g] && e_rdy[g];
            hs_slave = g;
            hs_last  = s_last[g];
        end
        check_eq("s_ready", s_ready, e_rdy);
        check_eq("m_valid", m_valid, e_mv);
        check_eq("dec_err", dec_err, e_dec);
        for (int m = 0; m < NUM_M; m++) begin
            if (e_mv[m]) begin
                check_eq("m_id", m_id[m*ID_BITS +: ID_BITS], s_id[g*IDS_BITS +: ID_BITS]);
                check_eq("m_data", m_data[m*DATA_BITS +: DATA_BITS],
                         s_data[g*DATA_BITS +: DATA_BITS]);
                check_eq("m_resp", m_resp[m*RESP_BITS +: RESP_BITS],
                         s_resp[g*RESP_BITS +: RESP_BITS]);
                check_eq("m_last", m_last[m], s_last[g]);
            end
        end
        rdy_smp = s_ready;
    endtask

    task automatic advance();
        logic [7:0] id;
        @(posedge clk);
        if (rst && hs_now) begin
            if (hs_last) begin
                mdl_lock = -1;
                mdl_ptr  = (hs_slave + 1) % NUM_S;
            end else begin
                mdl_lock = hs_slave;
            end
        end
        #1;
        for (int k = 0; k < NUM_S; k++) begin
            if (rem[k] > 0 && rdy_smp[k]) begin
                rem[k]--;
                if (rem[k] > 0) new_beat(k);
            end
        end
        if (rand_mode) begin
            for (int k = 0; k < NUM_S; k++) begin
                if (rem[k] == 0 && $urandom_range(0, 3) == 0) begin
                    id[7:4] = ($urandom_range(0, 7) == 0) ? 4'd3 : 4'($urandom_range(0, 2));
                    id[3:0] = 4'($urandom);
                    start_burst(k, $urandom_range(1, 5), id);
                end
            end
            m_ready = 3'($urandom);
        end
        apply();
    endtask

    task automatic cycle();
        #4;
        evaluate();
        advance();
    endtask

    task automatic run_until_idle(input int bound, output int cycles);
        int busy;
        cycles = 0;
        busy = 1;
        while (busy != 0 && cycles < bound) begin
            cycle();
            cycles++;
            busy = 0;
            for (int k = 0; k < NUM_S; k++) if (rem[k] > 0) busy++;
        end
        check_eq("drained", 64'(busy), 64'd0);
    endtask

    int cyc;

    initial begin
        for (int k = 0; k < NUM_S; k++) begin
            rem[k] = 0;
            bid[k] = '0;
        end
        // Reset state, with every slave requesting and every master ready.
        s_valid = '1;
        m_ready = '1;
        #12;
        evaluate();
        apply();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Two 4-beat bursts to m0 back to back, slave 0 first.
        m_ready = '1;
        start_burst(0, 4, 8'h07);
        start_burst(3, 4, 8'h0c);
        run_until_idle(20, cyc);
        check_eq("t1_cycles", 64'(cyc), 64'd8);

        // Slave 2 to m1 with m1 ready toggling; slave 5 waits behind the lock.
        start_burst(2, 4, 8'h1a);
        for (int c = 0; c < 12; c++) begin
            logic [3:0] pat;
            pat = 4'b1001;
            m_ready = {1'b1, (c < 4) ? pat[3-c] : 1'b1, 1'b1};
            if (c == 1) start_burst(5, 2, 8'h03);
            cycle();
        end
        check_eq("t2_rem2", 64'(rem[2]), 64'd0);
        check_eq("t2_rem5", 64'(rem[5]), 64'd0);

        // Route to m2 with the prefix stripped.
        m_ready = '1;
        start_burst(1, 1, 8'h25);
        run_until_idle(4, cyc);
        check_eq("t3_cycles", 64'(cyc), 64'd1);

        // Undecodable prefix: sunk regardless of master ready.
        m_ready = '0;
        start_burst(4, 3, 8'h31);
        run_until_idle(6, cyc);
        check_eq("t4_cycles", 64'(cyc), 64'd3);

        // Reset during beat 2 of a 4-beat burst.
        m_ready = '1;
        start_burst(0, 4, 8'h02);
        cycle();
        #2;
        rst = 1'b0;
        #1;
        evaluate();
        mdl_lock = -1;
        mdl_ptr  = 0;
        rem[0]   = 0;
        start_burst(6, 2, 8'h11);
        @(negedge clk);
        rst = 1'b1;
        #1;
        evaluate();
        check_eq("t5_gnt6", s_ready[6], 1'b1);
        advance();
        run_until_idle(6, cyc);

        // Randomized AXI-legal traffic.
        rand_mode = 1;
        for (int c = 0; c < 1500; c++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
